// File: rtl/wish_unpack_if.sv
// Wishbone-style source/destination bundle for the wide-to-narrow unpacker.
// slave  : the unpacker's view (accepts wide words, drives narrow beats).
// master : the environment's view (drives wide words, accepts narrow beats).
interface wish_unpack_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PACK   = 4,
   parameter int TGC_WIDTH  = 2
);
   logic                           s_stb_i;
   logic                           s_cyc_i;
   logic                           s_ack_o;
   logic                           s_stall_o;
   logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i;
   logic [TGC_WIDTH-1:0]           s_tgc_i;
   logic                           d_stb_o;
   logic                           d_cyc_o;
   logic                           d_ack_i;
   logic [DATA_WIDTH-1:0]          d_dat_o;
   logic [TGC_WIDTH-1:0]           d_tgc_o;
   logic                           d_last_o;

   modport slave (
      input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
      output s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_last_o
   );

   modport master (
      output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, d_ack_i,
      input  s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_last_o
   );
endinterface

// File: rtl/wish_unpack.sv
// Wide-to-narrow unpacker: one NUM_PACK*DATA_WIDTH word in, NUM_PACK beats out.
// A single holding register plus a beat index; a new word is taken in the same
// cycle the last beat of the current word is acked, so there are no bubbles.
module wish_unpack #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_PACK      = 4,
   parameter int TGC_WIDTH     = 2,
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   wish_unpack_if.slave  bus
);

   localparam int IW = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
   // LE walks slices upward from 0, BE walks downward from the top slice.
   localparam logic [IW-1:0] IDX_START = LITTLE_ENDIAN ? '0 : IW'(NUM_PACK - 1);
   localparam logic [IW-1:0] IDX_LAST  = LITTLE_ENDIAN ? IW'(NUM_PACK - 1) : '0;

   typedef enum logic {EMPTY = 1'b0, BUSY = 1'b1} state_t;

   state_t                               state_q, state_d;
   logic [NUM_PACK-1:0][DATA_WIDTH-1:0]  buf_q, buf_d;
   logic [TGC_WIDTH-1:0]                 tag_q, tag_d;
   logic [IW-1:0]                        idx_q, idx_d;

   logic valid, last_beat, beat, take, s_req, accept;

   assign valid     = (state_q == BUSY);
   assign last_beat = valid && (idx_q == IDX_LAST);
   assign beat      = valid && bus.d_ack_i;
   // Room for a new word: nothing held, or the final beat leaves this cycle.
   assign take      = !valid || (last_beat && bus.d_ack_i);
   assign s_req     = bus.s_stb_i && bus.s_cyc_i && !rst_i;
   assign accept    = s_req && take;

   assign bus.s_ack_o   = accept;
   assign bus.s_stall_o = s_req && !take;
   assign bus.d_stb_o   = valid;
   assign bus.d_cyc_o   = valid;
   assign bus.d_dat_o   = buf_q[idx_q];
   assign bus.d_tgc_o   = tag_q;
   assign bus.d_last_o  = last_beat;

   // Next state: advance the index on each beat, reload on an accepted word.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      tag_d   = tag_q;
      idx_d   = idx_q;
      if (beat) begin
         if (last_beat) begin
            idx_d   = IDX_START;
            state_d = EMPTY;
         end else if (LITTLE_ENDIAN) begin
            idx_d = idx_q + 1'b1;
         end else begin
            idx_d = idx_q - 1'b1;
         end
      end
      // An accept in the last-beat cycle overrides the drop to EMPTY.
      if (accept) begin
         buf_d   = bus.s_dat_i;
         tag_d   = bus.s_tgc_i;
         idx_d   = IDX_START;
         state_d = BUSY;
      end
   end

   // State registers; reset clears everything so all outputs read zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         buf_q   <= '0;
         tag_q   <= '0;
         idx_q   <= IDX_START;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         tag_q   <= tag_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_wish_unpack.sv
// Bench for wish_unpack: an LE and a BE instance share one stimulus stream;
// each has its own queue of expected beats, filled when a word is accepted.
module tb_wish_unpack;
   localparam int DW = 8;
   localparam int NP = 4;
   localparam int TW = 2;

   typedef struct packed {
      logic [TW-1:0]    tgc;
      logic [DW*NP-1:0] dat;
   } word_t;

   typedef struct packed {
      logic [TW-1:0] tgc;
      logic [DW-1:0] dat;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_stb = 1'b0, s_cyc = 1'b0, d_ack = 1'b0;
   logic [DW*NP-1:0] s_dat = '0;
   logic [TW-1:0]    s_tgc = '0;

   int vectors = 0, miscompares = 0;
   int ack_cnt = 0, stall_cnt = 0;
   bit rand_mode = 1'b0;

   word_t src_q[$];
   beat_t exp_le[$], exp_be[$];

   always #5 clk = ~clk;

   wish_unpack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) le_if ();
   wish_unpack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) be_if ();

   assign le_if.s_stb_i = s_stb;  assign be_if.s_stb_i = s_stb;
   assign le_if.s_cyc_i = s_cyc;  assign be_if.s_cyc_i = s_cyc;
   assign le_if.s_dat_i = s_dat;  assign be_if.s_dat_i = s_dat;
   assign le_if.s_tgc_i = s_tgc;  assign be_if.s_tgc_i = s_tgc;
   assign le_if.d_ack_i = d_ack;  assign be_if.d_ack_i = d_ack;

   wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1'b1)) u_le (
      .clk_i(clk), .rst_i(rst), .bus(le_if.slave));
   wish_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW), .LITTLE_ENDIAN(1'b0)) u_be (
      .clk_i(clk), .rst_i(rst), .bus(be_if.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic beat_t mk_beat(input word_t w, input int k, input bit le);
      beat_t b;
      int    s;
      s      = le ? k : NP - 1 - k;
      b.dat  = w.dat[s*DW +: DW];
      b.tgc  = w.tgc;
      b.last = (k == NP - 1);
      return b;
   endfunction

   // Source and random-ack driver, one step after each rising edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (src_q.size() != 0 && (!rand_mode || $urandom_range(3) != 0)) begin
            s_stb = 1'b1;
            s_cyc = rand_mode ? ($urandom_range(7) != 0) : 1'b1;
            s_dat = src_q[0].dat;
            s_tgc = src_q[0].tgc;
         end else begin
            s_stb = 1'b0;
            s_cyc = rand_mode ? ($urandom_range(1) != 0) : 1'b0;
            s_dat = $urandom;
         end
         if (rand_mode) d_ack = ($urandom_range(2) != 0);
      end
   end

   // Scoreboard/monitor on the falling edge.
   always @(negedge clk) begin
      bit    req, take_le, take_be;
      word_t w;
      if (!rst) begin
         req     = s_stb && s_cyc;
         take_le = (exp_le.size() == 0) || (exp_le.size() == 1 && d_ack);
         take_be = (exp_be.size() == 0) || (exp_be.size() == 1 && d_ack);

         chk("le_excl",  le_if.s_ack_o & le_if.s_stall_o, 0);
         chk("le_stb",   le_if.d_stb_o,   exp_le.size() != 0);
         chk("le_cyc",   le_if.d_cyc_o,   exp_le.size() != 0);
         chk("le_ack",   le_if.s_ack_o,   req && take_le);
         chk("le_stall", le_if.s_stall_o, req && !take_le);
         chk("le_last",  le_if.d_last_o,  exp_le.size() != 0 && exp_le[0].last);
         if (exp_le.size() != 0) begin
            chk("le_dat", le_if.d_dat_o, exp_le[0].dat);
            chk("le_tgc", le_if.d_tgc_o, exp_le[0].tgc);
            if (d_ack) void'(exp_le.pop_front());
         end

         chk("be_excl",  be_if.s_ack_o & be_if.s_stall_o, 0);
         chk("be_stb",   be_if.d_stb_o,   exp_be.size() != 0);
         chk("be_ack",   be_if.s_ack_o,   req && take_be);
         chk("be_stall", be_if.s_stall_o, req && !take_be);
         chk("be_last",  be_if.d_last_o,  exp_be.size() != 0 && exp_be[0].last);
         if (exp_be.size() != 0) begin
            chk("be_dat", be_if.d_dat_o, exp_be[0].dat);
            chk("be_tgc", be_if.d_tgc_o, exp_be[0].tgc);
            if (d_ack) void'(exp_be.pop_front());
         end

         if (le_if.s_stall_o) stall_cnt++;
         if (src_q.size() != 0 && (le_if.s_ack_o || be_if.s_ack_o)) begin
            w = src_q[0];
            if (le_if.s_ack_o) begin
               ack_cnt++;
               for (int k = 0; k < NP; k++) exp_le.push_back(mk_beat(w, k, 1'b1));
            end
            if (be_if.s_ack_o)
               for (int k = 0; k < NP; k++) exp_be.push_back(mk_beat(w, k, 1'b0));
            void'(src_q.pop_front());
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((src_q.size() != 0 || exp_le.size() != 0 || exp_be.size() != 0) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk("idle_timeout", n < budget, 1);
      @(negedge clk); #1;
   endtask

   task automatic wait_accept(input int budget);
      int n = 0;
      while (exp_le.size() == 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk("accept_timeout", n < budget, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_le_stb"},  le_if.d_stb_o,   0);
      chk({tag, "_le_cyc"},  le_if.d_cyc_o,   0);
      chk({tag, "_le_last"}, le_if.d_last_o,  0);
      chk({tag, "_le_dat"},  le_if.d_dat_o,   0);
      chk({tag, "_le_tgc"},  le_if.d_tgc_o,   0);
      chk({tag, "_le_ack"},  le_if.s_ack_o,   0);
      chk({tag, "_le_stl"},  le_if.s_stall_o, 0);
      chk({tag, "_be_stb"},  be_if.d_stb_o,   0);
      chk({tag, "_be_dat"},  be_if.d_dat_o,   0);
   endtask

   initial begin
      word_t w;
      // Reset with a request already pending: nothing may respond.
      src_q.push_back('{tgc: 2'b01, dat: 32'hDDCCBBAA});
      d_ack = 1'b1;
      @(negedge clk); @(negedge clk);
      chk_zero("rst");

      // Single word, ack held high.
      @(posedge clk); #1; rst = 1'b0;
      ack_cnt = 0; stall_cnt = 0;
      wait_idle(50);
      chk("t1_acks", ack_cnt, 1);
      chk("t1_stalls", stall_cnt, 0);

      // Back-to-back words, reload with no bubble.
      ack_cnt = 0; stall_cnt = 0;
      src_q.push_back('{tgc: 2'b10, dat: 32'h44332211});
      src_q.push_back('{tgc: 2'b11, dat: 32'h88776655});
      wait_idle(60);
      chk("t3_acks", ack_cnt, 2);
      chk("t3_stalls", stall_cnt, 3);

      // Backpressure on beat BB with a second word pending.
      src_q.push_back('{tgc: 2'b00, dat: 32'hDDCCBBAA});
      src_q.push_back('{tgc: 2'b11, dat: 32'h12345678});
      wait_accept(20);
      @(posedge clk); #1;               // AA on the bus, acked
      @(posedge clk); #1; d_ack = 1'b0; // BB on the bus, held
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_dat", le_if.d_dat_o, 8'hBB);
         chk("bp_stall", le_if.s_stall_o, 1);
         @(posedge clk); #1;
      end
      d_ack = 1'b1;
      wait_idle(60);

      // Reset in the middle of a word discards the rest.
      src_q.push_back('{tgc: 2'b01, dat: 32'hDDCCBBAA});
      wait_accept(20);
      @(posedge clk); #1;               // AA
      @(posedge clk); #1;               // BB
      #2 rst = 1'b1;
      #1 chk_zero("midrst");
      exp_le.delete();
      exp_be.delete();
      @(posedge clk); #1;
      @(posedge clk); #1; rst = 1'b0;
      src_q.push_back('{tgc: 2'b10, dat: 32'h04030201});
      wait_idle(40);

      // Random strobe/cycle/ack stress.
      ack_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         w.dat = $urandom;
         w.tgc = TW'($urandom_range(3));
         src_q.push_back(w);
      end
      rand_mode = 1'b1;
      while (src_q.size() != 0 || exp_le.size() != 0 || exp_be.size() != 0) begin
         @(negedge clk); #1;
         if (ack_cnt > 24 || $time > 200000) break;
      end
      rand_mode = 1'b0;
      d_ack = 1'b1;
      chk("stress_drained", src_q.size() + exp_le.size() + exp_be.size(), 0);
      chk("stress_acks", ack_cnt, 24);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wish_unpack.md
Name: wish_unpack

Overview:
- Downstream counterpart of the packer. Accepts one wide word of NUM_PACK*DATA_WIDTH bits per Wishbone-style source transfer and emits it as NUM_PACK narrow beats on a Wishbone-style destination port.
- Used where a packed stream must be narrowed again, such as before a byte-wide sink.
- A single holding register plus a beat index gives full throughput: a new wide word can be accepted in the same cycle the last beat of the previous word is acked.

Parameters:
- DATA_WIDTH, 8, width of one narrow beat.
- NUM_PACK, 4, beats per wide word; must be >= 2.
- TGC_WIDTH, 2, width of the cycle tag.
- LITTLE_ENDIAN, 1, 1 = lowest slice emitted first; 0 = highest slice emitted first.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_stb_i  in  1  source strobe.
- s_cyc_i  in  1  source cycle valid.
- s_ack_o  out  1  source word accepted this cycle.
- s_stall_o  out  1  source request present but cannot be accepted.
- s_dat_i  in  DATA_WIDTH*NUM_PACK  wide source word.
- s_tgc_i  in  TGC_WIDTH  source tag.
- d_stb_o  out  1  destination beat valid.
- d_cyc_o  out  1  destination cycle; identical to d_stb_o.
- d_ack_i  in  1  destination accepts beat.
- d_dat_o  out  DATA_WIDTH  current narrow beat.
- d_tgc_o  out  TGC_WIDTH  tag of the word being unpacked, held on every beat.
- d_last_o  out  1  current beat is the final slice of the word.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - clears valid, buffer, tag and index.
  - index = 0 if LITTLE_ENDIAN, else NUM_PACK-1.
  - While rst_i is high: d_stb_o = d_cyc_o = d_last_o = 0, d_dat_o = 0, d_tgc_o = 0, s_ack_o = 0, s_stall_o = 0.
- State:
  - valid flag (1 bit).
  - wide buffer.
  - tag register.
  - index, $clog2(NUM_PACK) bits.
  - The block has two states, EMPTY (valid = 0) and BUSY (valid = 1).
- Destination side:
  - d_stb_o = d_cyc_o = valid.
  - d_dat_o = buffer slice [index*DATA_WIDTH +: DATA_WIDTH].
  - d_tgc_o = tag register.
  - d_last_o = valid && (index == NUM_PACK-1 if LITTLE_ENDIAN, else index == 0).
  - Beat transfer: d_stb_o && d_ack_i. d_ack_i while d_stb_o = 0 is ignored.
  - d_dat_o and d_tgc_o hold stable while d_stb_o is high and d_ack_i is low.
- Index on a beat transfer:
  - If not the last beat: step by +1 (LE) or -1 (BE).
  - If the last beat: return to the start value (0 for LE, NUM_PACK-1 for BE).
- Source side:
  - Define take = !valid || (d_last_o && d_ack_i).
  - s_ack_o = s_stb_i && s_cyc_i && take && !rst_i. This is combinational and has a path from d_ack_i.
  - s_stall_o = s_stb_i && s_cyc_i && !take && !rst_i.
  - s_ack_o and s_stall_o are never high together.
  - s_ack_o means the word is consumed in that cycle. The source must present the next word or drop s_stb_i on the next cycle.
- Transitions:
  - EMPTY to BUSY on s_ack_o: load buffer from s_dat_i and tag from s_tgc_i; index is at its start value.
  - BUSY to EMPTY on a last-beat transfer with no s_ack_o.
  - BUSY to BUSY (reload) on a last-beat transfer together with s_ack_o in the same cycle. The new word's first beat appears the next cycle, with no bubble.
- Latency: first beat is valid one cycle after s_ack_o.
- Throughput: one narrow beat per cycle with d_ack_i held high. A wide word is accepted every NUM_PACK cycles.
- s_cyc_i dropping with s_stb_i low: no effect. A word already buffered is still fully emitted.
- Reset mid-word discards the remaining beats. The next word starts at the start index.

Test Plan:
- LE, reset then one word 0xDDCCBBAA with tgc 2'b01, d_ack_i = 1 -> s_ack_o pulses once. Then beats AA, BB, CC, DD on 4 consecutive cycles, d_tgc_o = 01 on all, d_last_o only with DD, then d_stb_o = 0.
- LITTLE_ENDIAN = 0, same word -> beats DD, CC, BB, AA; d_last_o on AA.
- Back-to-back words 0x44332211 and 0x88776655, d_ack_i = 1 -> second s_ack_o in the same cycle as the beat 44 ack. Output is 11..44 then 55..88 with no idle cycle. Between the two acks s_stall_o = 1 for 3 cycles.
- Backpressure: d_ack_i low for 3 cycles on beat BB -> d_dat_o holds BB, s_stall_o stays high for a pending source. Afterwards CC and DD follow in order.
- Reset asserted after beat AA acked -> outputs zero immediately (asynchronously). After release, a new word 0x04030201 emits 01 first.
- Random stb/cyc/ack stress -> s_ack_o && s_stall_o never both high. Concatenating the destination beats reproduces the source words, with matching tags.
